// File: rtl/muskoka_pkg.sv
// Shared definitions for the muskoka bus arbiter: state encoding and default widths.
package muskoka_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam int DEF_DATA_WIDTH = 32;

    // One-hot grant vector (bit 0 = m0, bit 1 = m1) for a given arbiter state.
    function automatic logic [1:0] state_to_gnt(arb_state_t s);
        return {s == GNT1, s == GNT0};
    endfunction

endpackage

// File: rtl/muskoka_wb_watchdog.sv
// Ack watchdog: counts cycles of an unanswered granted strobe and flags expiry
// on the TIMEOUT-th such cycle, then starts over.
module muskoka_wb_watchdog #(
    parameter int TIMEOUT = 255
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic clr,
    input  logic run,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(TIMEOUT - 1);

    logic [CW-1:0] count_reg;

    // clr carries the ack/err condition, so an answer in the final cycle suppresses expiry.
    assign expire = run && !clr && (count_reg == LAST_COUNT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            count_reg <= '0;
        end else if (clr || expire) begin
            count_reg <= '0;
        end else if (run) begin
            count_reg <= count_reg + 1'b1;
        end
    end

endmodule

// File: rtl/muskoka_wb_arbiter.sv
// Two-master Wishbone arbiter (m0 = instruction fetch, m1 = load/store) with
// round-robin grants held for the whole cyc, plus an ack watchdog.
module muskoka_wb_arbiter
    import muskoka_pkg::*;
#(
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int TIMEOUT    = 255
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    m0_cyc_i,
    input  logic                    m0_stb_i,
    input  logic                    m0_we_i,
    input  logic [DATA_WIDTH/8-1:0] m0_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m0_adr_i,
    input  logic [DATA_WIDTH-1:0]   m0_dat_i,
    output logic [DATA_WIDTH-1:0]   m0_dat_o,
    output logic                    m0_ack_o,
    output logic                    m0_err_o,
    input  logic                    m1_cyc_i,
    input  logic                    m1_stb_i,
    input  logic                    m1_we_i,
    input  logic [DATA_WIDTH/8-1:0] m1_sel_i,
    input  logic [ADDR_WIDTH-1:0]   m1_adr_i,
    input  logic [DATA_WIDTH-1:0]   m1_dat_i,
    output logic [DATA_WIDTH-1:0]   m1_dat_o,
    output logic                    m1_ack_o,
    output logic                    m1_err_o,
    output logic                    s_cyc_o,
    output logic                    s_stb_o,
    output logic                    s_we_o,
    output logic [DATA_WIDTH/8-1:0] s_sel_o,
    output logic [ADDR_WIDTH-1:0]   s_adr_o,
    output logic [DATA_WIDTH-1:0]   s_dat_o,
    input  logic [DATA_WIDTH-1:0]   s_dat_i,
    input  logic                    s_ack_i,
    input  logic                    s_err_i,
    output logic [1:0]              gnt_o
);

    arb_state_t state_reg, state_next;
    logic       last_reg, last_next;
    logic [1:0] gnt;
    logic       sel_stb;
    logic       wd_expire;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_reg <= IDLE;
            last_reg  <= 1'b1;
        end else begin
            state_reg <= state_next;
            last_reg  <= last_next;
        end
    end

    // Owners always pass through IDLE, so a handover costs one dead cycle.
    always_comb begin
        state_next = state_reg;
        last_next  = last_reg;
        case (state_reg)
            IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = last_reg ? GNT0 : GNT1;
                end else if (m0_cyc_i) begin
                    state_next = GNT0;
                end else if (m1_cyc_i) begin
                    state_next = GNT1;
                end
            end
            GNT0: begin
                if (!m0_cyc_i) begin
                    state_next = IDLE;
                    last_next  = 1'b0;
                end
            end
            GNT1: begin
                if (!m1_cyc_i) begin
                    state_next = IDLE;
                    last_next  = 1'b1;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign gnt   = state_to_gnt(state_reg);
    assign gnt_o = gnt;

    always_comb begin
        s_cyc_o = 1'b0;
        sel_stb = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        if (gnt[0]) begin
            s_cyc_o = m0_cyc_i;
            sel_stb = m0_stb_i;
            s_we_o  = m0_we_i;
            s_sel_o = m0_sel_i;
            s_adr_o = m0_adr_i;
            s_dat_o = m0_dat_i;
        end else if (gnt[1]) begin
            s_cyc_o = m1_cyc_i;
            sel_stb = m1_stb_i;
            s_we_o  = m1_we_i;
            s_sel_o = m1_sel_i;
            s_adr_o = m1_adr_i;
            s_dat_o = m1_dat_i;
        end
    end

    // The expiring strobe is withheld so the slave never sees a late access.
    assign s_stb_o = sel_stb && !wd_expire;

    muskoka_wb_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .clr    ((state_reg == IDLE) || !sel_stb || s_ack_i || s_err_i),
        .run    (sel_stb),
        .expire (wd_expire)
    );

    logic [DATA_WIDTH-1:0] mst_dat [2];
    logic [1:0]            mst_ack;
    logic [1:0]            mst_err;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_return
            assign mst_dat[gi] = gnt[gi] ? s_dat_i : '0;
            assign mst_ack[gi] = gnt[gi] && s_ack_i;
            assign mst_err[gi] = gnt[gi] && (s_err_i || wd_expire);
        end
    endgenerate

    assign m0_dat_o = mst_dat[0];
    assign m0_ack_o = mst_ack[0];
    assign m0_err_o = mst_err[0];
    assign m1_dat_o = mst_dat[1];
    assign m1_ack_o = mst_ack[1];
    assign m1_err_o = mst_err[1];

endmodule

// File: tb/tb_muskoka_wb_arbiter.sv
// Directed bench for muskoka_wb_arbiter: a per-cycle vector table for
// arbitration/muxing plus hand sequences for data, watchdog and async reset.
module tb_muskoka_wb_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        m0_cyc_i = 0, m0_stb_i = 0, m0_we_i = 0;
    logic [3:0]  m0_sel_i = 4'hF;
    logic [31:0] m0_adr_i = 32'h0000_1000, m0_dat_i = 32'h1111_1111;
    logic [31:0] m0_dat_o;
    logic        m0_ack_o, m0_err_o;
    logic        m1_cyc_i = 0, m1_stb_i = 0, m1_we_i = 0;
    logic [3:0]  m1_sel_i = 4'h3;
    logic [31:0] m1_adr_i = 32'h0, m1_dat_i = 32'h2222_2222;
    logic [31:0] m1_dat_o;
    logic        m1_ack_o, m1_err_o;
    logic        s_cyc_o, s_stb_o, s_we_o;
    logic [3:0]  s_sel_o;
    logic [31:0] s_adr_o, s_dat_o;
    logic [31:0] s_dat_i = 32'h0;
    logic        s_ack_i = 0, s_err_i = 0;
    logic [1:0]  gnt_o;

    int errors = 0;
    int checks = 0;

    always #5 clk_i = ~clk_i;

    muskoka_wb_arbiter #(
        .ADDR_WIDTH (32),
        .DATA_WIDTH (32),
        .TIMEOUT    (8)
    ) dut (
        .clk_i (clk_i), .rst_i (rst_i),
        .m0_cyc_i (m0_cyc_i), .m0_stb_i (m0_stb_i), .m0_we_i (m0_we_i),
        .m0_sel_i (m0_sel_i), .m0_adr_i (m0_adr_i), .m0_dat_i (m0_dat_i),
        .m0_dat_o (m0_dat_o), .m0_ack_o (m0_ack_o), .m0_err_o (m0_err_o),
        .m1_cyc_i (m1_cyc_i), .m1_stb_i (m1_stb_i), .m1_we_i (m1_we_i),
        .m1_sel_i (m1_sel_i), .m1_adr_i (m1_adr_i), .m1_dat_i (m1_dat_i),
        .m1_dat_o (m1_dat_o), .m1_ack_o (m1_ack_o), .m1_err_o (m1_err_o),
        .s_cyc_o (s_cyc_o), .s_stb_o (s_stb_o), .s_we_o (s_we_o),
        .s_sel_o (s_sel_o), .s_adr_o (s_adr_o), .s_dat_o (s_dat_o),
        .s_dat_i (s_dat_i), .s_ack_i (s_ack_i), .s_err_i (s_err_i),
        .gnt_o (gnt_o)
    );

    typedef struct {
        logic        m0c, m0s, m1c, m1s, ack, err;
        logic [31:0] m1_adr;
        logic [1:0]  e_gnt;
        logic        e_cyc, e_stb, e_a0, e_a1, e_e0, e_e1;
        logic [31:0] e_adr;
    } vec_t;

    localparam int NV = 32;
    vec_t tbl [NV];

    function automatic vec_t mk(logic m0c, logic m0s, logic m1c, logic m1s,
                                logic ack, logic err, logic [31:0] m1_adr,
                                logic [1:0] e_gnt, logic e_cyc, logic e_stb,
                                logic e_a0, logic e_a1, logic e_e0, logic e_e1,
                                logic [31:0] e_adr);
        vec_t v;
        v.m0c = m0c; v.m0s = m0s; v.m1c = m1c; v.m1s = m1s;
        v.ack = ack; v.err = err; v.m1_adr = m1_adr;
        v.e_gnt = e_gnt; v.e_cyc = e_cyc; v.e_stb = e_stb;
        v.e_a0 = e_a0; v.e_a1 = e_a1; v.e_e0 = e_e0; v.e_e1 = e_e1;
        v.e_adr = e_adr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    task automatic next_cycle();
        @(negedge clk_i);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        // Tie after reset: m0 wins, one IDLE cycle, then m1
        tbl[0]  = mk(1,1,1,1,0,0,32'h2000, 2'b00,0,0,0,0,0,0,32'h0);
        tbl[1]  = mk(1,1,1,1,0,0,32'h2000, 2'b01,1,1,0,0,0,0,32'h1000);
        tbl[2]  = mk(1,1,1,1,1,0,32'h2000, 2'b01,1,1,1,0,0,0,32'h1000);
        tbl[3]  = mk(0,0,1,1,0,0,32'h2000, 2'b01,0,0,0,0,0,0,32'h1000);
        tbl[4]  = mk(0,0,1,1,0,0,32'h2000, 2'b00,0,0,0,0,0,0,32'h0);
        tbl[5]  = mk(0,0,1,1,0,0,32'h2000, 2'b10,1,1,0,0,0,0,32'h2000);
        tbl[6]  = mk(0,0,1,1,1,0,32'h2000, 2'b10,1,1,0,1,0,0,32'h2000);
        tbl[7]  = mk(0,0,0,0,0,0,32'h2000, 2'b10,0,0,0,0,0,0,32'h2000);
        tbl[8]  = mk(0,0,0,0,0,0,32'h2000, 2'b00,0,0,0,0,0,0,32'h0);
        // Single m0 read, ack two cycles after first strobe
        tbl[9]  = mk(1,1,0,0,0,0,32'h2000, 2'b00,0,0,0,0,0,0,32'h0);
        tbl[10] = mk(1,1,0,0,0,0,32'h2000, 2'b01,1,1,0,0,0,0,32'h1000);
        tbl[11] = mk(1,1,0,0,0,0,32'h2000, 2'b01,1,1,0,0,0,0,32'h1000);
        tbl[12] = mk(1,1,0,0,1,0,32'h2000, 2'b01,1,1,1,0,0,0,32'h1000);
        tbl[13] = mk(0,0,0,0,0,0,32'h2000, 2'b01,0,0,0,0,0,0,32'h1000);
        tbl[14] = mk(0,0,0,0,0,0,32'h2000, 2'b00,0,0,0,0,0,0,32'h0);
        // Tie with last=0: m1 first, locked 4-beat burst while m0 waits
        tbl[15] = mk(1,1,1,1,0,0,32'h10,   2'b00,0,0,0,0,0,0,32'h0);
        tbl[16] = mk(1,1,1,1,0,0,32'h10,   2'b10,1,1,0,0,0,0,32'h10);
        tbl[17] = mk(1,1,1,1,1,0,32'h10,   2'b10,1,1,0,1,0,0,32'h10);
        tbl[18] = mk(1,1,1,1,1,0,32'h14,   2'b10,1,1,0,1,0,0,32'h14);
        tbl[19] = mk(1,1,1,1,1,0,32'h18,   2'b10,1,1,0,1,0,0,32'h18);
        tbl[20] = mk(1,1,1,1,1,0,32'h1C,   2'b10,1,1,0,1,0,0,32'h1C);
        tbl[21] = mk(1,1,0,0,0,0,32'h1C,   2'b10,0,0,0,0,0,0,32'h1C);
        tbl[22] = mk(1,1,0,0,0,0,32'h1C,   2'b00,0,0,0,0,0,0,32'h0);
        tbl[23] = mk(1,1,0,0,0,0,32'h1C,   2'b01,1,1,0,0,0,0,32'h1000);
        tbl[24] = mk(0,0,0,0,0,0,32'h1C,   2'b01,0,0,0,0,0,0,32'h1000);
        tbl[25] = mk(0,0,0,0,0,0,32'h3000, 2'b00,0,0,0,0,0,0,32'h0);
        // Slave error on m1, then ack+err together, grant held until cyc drops
        tbl[26] = mk(0,0,1,1,0,0,32'h3000, 2'b00,0,0,0,0,0,0,32'h0);
        tbl[27] = mk(0,0,1,1,0,1,32'h3000, 2'b10,1,1,0,0,0,1,32'h3000);
        tbl[28] = mk(0,0,1,1,1,1,32'h3000, 2'b10,1,1,0,1,0,1,32'h3000);
        tbl[29] = mk(0,0,1,0,0,0,32'h3000, 2'b10,1,0,0,0,0,0,32'h3000);
        tbl[30] = mk(0,0,0,0,0,0,32'h3000, 2'b10,0,0,0,0,0,0,32'h3000);
        tbl[31] = mk(0,0,0,0,0,0,32'h3000, 2'b00,0,0,0,0,0,0,32'h0);

        // Reset state while a master is already requesting
        m0_cyc_i = 1; m0_stb_i = 1;
        repeat (3) @(negedge clk_i);
        #1;
        check("reset gnt", 32'(gnt_o), 32'h0);
        check("reset s_cyc", 32'(s_cyc_o), 32'h0);
        check("reset s_stb", 32'(s_stb_o), 32'h0);
        check("reset m0_dat", m0_dat_o, 32'h0);
        check("reset m0_ack_err", 32'({m0_ack_o, m0_err_o, m1_ack_o, m1_err_o}), 32'h0);
        $display("txn reset: gnt=%b s_cyc=%b s_stb=%b", gnt_o, s_cyc_o, s_stb_o);
        m0_cyc_i = 0; m0_stb_i = 0;
        rst_i = 0;

        for (int i = 0; i < NV; i++) begin
            m0_cyc_i = tbl[i].m0c; m0_stb_i = tbl[i].m0s;
            m1_cyc_i = tbl[i].m1c; m1_stb_i = tbl[i].m1s;
            s_ack_i = tbl[i].ack; s_err_i = tbl[i].err;
            m1_adr_i = tbl[i].m1_adr;
            #1;
            check($sformatf("row%0d gnt", i), 32'(gnt_o), 32'(tbl[i].e_gnt));
            check($sformatf("row%0d s_cyc", i), 32'(s_cyc_o), 32'(tbl[i].e_cyc));
            check($sformatf("row%0d s_stb", i), 32'(s_stb_o), 32'(tbl[i].e_stb));
            check($sformatf("row%0d acks", i), 32'({m0_ack_o, m1_ack_o}), 32'({tbl[i].e_a0, tbl[i].e_a1}));
            check($sformatf("row%0d errs", i), 32'({m0_err_o, m1_err_o}), 32'({tbl[i].e_e0, tbl[i].e_e1}));
            check($sformatf("row%0d s_adr", i), s_adr_o, tbl[i].e_adr);
            $display("txn row%0d: gnt=%b stb=%b ack=%b%b err=%b%b adr=%h",
                     i, gnt_o, s_stb_o, m0_ack_o, m1_ack_o, m0_err_o, m1_err_o, s_adr_o);
            @(negedge clk_i);
        end
        s_ack_i = 0; s_err_i = 0;

        // m0 read data return (last=1 here, m0 alone)
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000; s_dat_i = 32'hDEAD_BEEF;
        #1;
        check("rd idle gnt", 32'(gnt_o), 32'h0);
        next_cycle();
        check("rd gnt", 32'(gnt_o), 32'h1);
        next_cycle();
        @(negedge clk_i);
        s_ack_i = 1;
        #1;
        check("rd m0_ack", 32'(m0_ack_o), 32'h1);
        check("rd m0_dat", m0_dat_o, 32'hDEAD_BEEF);
        check("rd m1_ack", 32'(m1_ack_o), 32'h0);
        check("rd m1_dat", m1_dat_o, 32'h0);
        $display("txn read m0: dat=%h ack=%b", m0_dat_o, m0_ack_o);
        @(negedge clk_i);
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        repeat (2) @(negedge clk_i);

        // Watchdog expiry: err on the 8th strobed cycle, strobe withheld then
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_DEAD;
        @(negedge clk_i);
        for (int n = 1; n <= 9; n++) begin
            #1;
            check($sformatf("wd n%0d m0_err", n), 32'(m0_err_o), (n == 8) ? 32'h1 : 32'h0);
            check($sformatf("wd n%0d s_stb", n), 32'(s_stb_o), (n == 8) ? 32'h0 : 32'h1);
            @(negedge clk_i);
        end
        $display("txn watchdog timeout m0");
        m0_cyc_i = 0; m0_stb_i = 0;
        repeat (2) @(negedge clk_i);

        // Ack on the expiry cycle wins
        m0_cyc_i = 1; m0_stb_i = 1;
        @(negedge clk_i);
        for (int n = 1; n <= 8; n++) begin
            s_ack_i = (n == 8);
            #1;
            if (n == 8) begin
                check("wdack m0_ack", 32'(m0_ack_o), 32'h1);
                check("wdack m0_err", 32'(m0_err_o), 32'h0);
                check("wdack s_stb", 32'(s_stb_o), 32'h1);
            end else begin
                check($sformatf("wdack n%0d m0_err", n), 32'(m0_err_o), 32'h0);
            end
            @(negedge clk_i);
        end
        $display("txn watchdog ack-wins m0");
        s_ack_i = 0; m0_cyc_i = 0; m0_stb_i = 0;
        repeat (2) @(negedge clk_i);

        // Async reset during an m1 write
        m1_cyc_i = 1; m1_stb_i = 1; m1_we_i = 1; m1_sel_i = 4'hC;
        m1_adr_i = 32'h0000_4000; m1_dat_i = 32'hCAFE_F00D;
        next_cycle();
        check("wr gnt", 32'(gnt_o), 32'h2);
        check("wr s_we", 32'(s_we_o), 32'h1);
        check("wr s_sel", 32'(s_sel_o), 32'hC);
        check("wr s_dat", s_dat_o, 32'hCAFE_F00D);
        @(posedge clk_i);
        #2;
        rst_i = 1;
        #1;
        check("arst s_cyc", 32'(s_cyc_o), 32'h0);
        check("arst s_stb", 32'(s_stb_o), 32'h0);
        check("arst gnt", 32'(gnt_o), 32'h0);
        $display("txn async reset during m1 write");
        @(negedge clk_i);
        rst_i = 0;
        m1_cyc_i = 0; m1_stb_i = 0; m1_we_i = 0;
        m0_cyc_i = 1; m0_stb_i = 1; m0_adr_i = 32'h0000_1000;
        #1;
        check("post-rst idle gnt", 32'(gnt_o), 32'h0);
        next_cycle();
        check("post-rst gnt", 32'(gnt_o), 32'h1);
        check("post-rst s_stb", 32'(s_stb_o), 32'h1);
        $display("txn m0 after reset: gnt=%b", gnt_o);
        m0_cyc_i = 0; m0_stb_i = 0;
        repeat (2) @(negedge clk_i);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
